tri_scan_ring_ctl: RTL and testbench
====================================

TRI_SCAN_RING_CTL -- requirements
Module: tri_scan_ring_ctl

Interface
REQ-001 SHALL have parameter RING_LEN, default 32: number of latches in the controlled scan ring.
REQ-002 SHALL have parameter CNT_W, default 6: shift-counter width, at least ceil(log2(RING_LEN+1)).
REQ-003 SHALL have port nclk, input, [0:`NCLK_WIDTH-1]: nclk[0] is the single clock; nclk[1] is the reset, synchronous and active-high.
REQ-004 SHALL have port req_val, input, 1: access request valid.
REQ-005 SHALL have port req_rdy, output, 1: controller can accept a request.
REQ-006 SHALL have port req_wr, input, 1: 1 = write req_wdata into the ring; 0 = read-only access (recirculate).
REQ-007 SHALL have port req_wdata, input, [0:RING_LEN-1]: new ring contents.
REQ-008 SHALL have port rsp_val, output, 1: response valid.
REQ-009 SHALL have port rsp_rdy, input, 1: response accepted.
REQ-010 SHALL have port rsp_rdata, output, [0:RING_LEN-1]: ring contents before the access.
REQ-011 SHALL have port rsp_par, output, 1: XOR of rsp_rdata.
REQ-012 SHALL have port ring_hold, output, 1: functional hold, which drives the ring's thold_b low.
REQ-013 SHALL have port ring_sg, output, 1: scan gate to the ring.
REQ-014 SHALL have port ring_scin, output, 1: serial data into the ring's first latch.
REQ-015 SHALL have port ring_scout, input, 1: serial data from the ring's last latch.

Function
REQ-016 SHALL implement the FSM IDLE -> HOLD -> SHIFT -> RELEASE -> RESP -> IDLE.
REQ-017 SHALL assert req_rdy only in IDLE; a request is accepted on the edge where req_val and req_rdy are both 1.
REQ-018 SHALL ignore req_val outside IDLE; no request is queued.
REQ-019 SHALL, on acceptance, latch req_wr and req_wdata into an internal RING_LEN-bit shift register.
REQ-020 SHALL stay in HOLD for exactly one cycle with ring_hold=1 and ring_sg=0.
REQ-021 SHALL stay in SHIFT for exactly RING_LEN cycles with ring_hold=1 and ring_sg=1, counting with a CNT_W counter.
REQ-022 SHALL, in SHIFT cycle k (k=0..RING_LEN-1), drive ring_scin = wdata[RING_LEN-1-k] when req_wr=1.
REQ-023 SHALL, in SHIFT cycle k when req_wr=0, drive ring_scin = ring_scout (same cycle), so the ring contents are preserved.
REQ-024 SHALL, in SHIFT cycle k, capture ring_scout into rdata[RING_LEN-1-k].
REQ-025 SHALL therefore give swap semantics: rsp_rdata[i] is the ring bit that wdata[i] replaced.
REQ-026 SHALL stay in RELEASE for exactly one cycle with ring_sg=0 and ring_hold=1; ring_hold SHALL be 0 in every other state.
REQ-027 SHALL hold rsp_val=1, with rsp_rdata and rsp_par stable, throughout RESP until rsp_rdy=1, then return to IDLE.
REQ-028 SHALL meet this timing for acceptance at edge T: HOLD in cycle T+1; SHIFT in cycles T+2..T+1+RING_LEN; RELEASE in T+2+RING_LEN; rsp_val from T+3+RING_LEN.
REQ-029 SHALL allow minimum request-to-request spacing of RING_LEN+4 cycles: next request accepted one cycle after the response handshake.
REQ-030 SHALL keep ring_sg=0 and ring_scin=0 outside SHIFT.

Reset
REQ-031 SHALL, while nclk[1]=1 at an edge, enter IDLE and clear the counter, the shift register, rsp_rdata, rsp_par, rsp_val, ring_hold and ring_sg.
REQ-032 SHALL drive req_rdy=1 in the first cycle after reset deasserts.
REQ-033 SHALL, on reset in any state including mid-SHIFT, abandon the access (ring contents undefined) and produce no response.

Configuration
REQ-034 SHALL, with macro TRI_SCAN_RING_PARITY_EN defined, register rsp_par as the XOR of captured rdata, updated on the same edge as rsp_val rises.
REQ-035 SHALL, without TRI_SCAN_RING_PARITY_EN, tie rsp_par to 0 and instantiate no parity logic.

Verification (RING_LEN=8, behavioral 8-bit ring model initialised to 0xA5)
REQ-036 SHALL cover write: req_wr=1, wdata=0x3C -> rsp_val at T+11; rsp_rdata=0xA5; ring model=0x3C; rsp_par=0 with macro.
REQ-037 SHALL cover read-only: req_wr=0 on ring 0x3C -> rsp_rdata=0x3C; ring unchanged; ring_sg high exactly 8 cycles.
REQ-038 SHALL cover back-pressure: hold rsp_rdy=0 for 5 cycles -> rsp_val and rsp_rdata stable; req_val during this time ignored with req_rdy=0.
REQ-039 SHALL cover reset mid-SHIFT at shift cycle 3 -> next cycle IDLE, ring_sg=0, ring_hold=0, no rsp_val; following write completes normally.
REQ-040 SHALL cover back-to-back: req_val held high with rsp_rdy=1 -> accepts spaced exactly 12 cycles apart.
REQ-041 SHALL cover macro off: wdata=0x01 written then read -> rsp_par=0 always.

Source files
------------

// File: rtl/tri_scan_ring_ctl.sv
// rtl/tri_scan_ring_ctl.sv - scan-ring swap access controller: hold, shift RING_LEN bits, release, respond
// Optional registered response parity is enabled by defining TRI_SCAN_RING_PARITY_EN.
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 2
`endif

module tri_scan_ring_ctl #(
    parameter int RING_LEN = 32,
    parameter int CNT_W    = 6
) (
    input  logic [0:`NCLK_WIDTH-1] nclk,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic                   req_wr,
    input  logic [0:RING_LEN-1]    req_wdata,
    output logic                   rsp_val,
    input  logic                   rsp_rdy,
    output logic [0:RING_LEN-1]    rsp_rdata,
    output logic                   rsp_par,
    output logic                   ring_hold,
    output logic                   ring_sg,
    output logic                   ring_scin,
    input  logic                   ring_scout
);
    typedef enum logic [2:0] {IDLE, HOLD, SHIFT, RELEASE, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RING_LEN - 1);

    logic clk;
    logic rst;
    assign clk = nclk[0];
    assign rst = nclk[1];

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [0:RING_LEN-1] sr_q, sr_d;
    logic                wr_q, wr_d;
    logic [0:RING_LEN-1] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // One shift register serves both directions: write data leaves from the tail
    // while captured scout enters at the head, ending up as the pre-access image.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        wr_d      = wr_q;
        rdata_d   = rdata_q;
        req_rdy   = 1'b0;
        rsp_val   = 1'b0;
        ring_hold = 1'b0;
        ring_sg   = 1'b0;
        ring_scin = 1'b0;
        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    sr_d    = req_wdata;
                    wr_d    = req_wr;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                ring_hold = 1'b1;
                state_d   = SHIFT;
            end
            SHIFT: begin
                ring_hold = 1'b1;
                ring_sg   = 1'b1;
                ring_scin = wr_q ? sr_q[RING_LEN-1] : ring_scout;
                sr_d      = {ring_scout, sr_q[0:RING_LEN-2]};
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                ring_hold = 1'b1;
                rdata_d   = sr_q;
                state_d   = RESP;
            end
            RESP: begin
                rsp_val = 1'b1;
                if (rsp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_rdata = rdata_q;

`ifdef TRI_SCAN_RING_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (state_q == RELEASE) begin
            par_d = ^sr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign rsp_par = par_q;
`else
    assign rsp_par = 1'b0;
`endif

endmodule

// File: tb/tb_tri_scan_ring_ctl.sv
// tb/tb_tri_scan_ring_ctl.sv - scoreboard bench for tri_scan_ring_ctl with an 8-latch behavioural ring
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 2
`endif

module tb_tri_scan_ring_ctl;
    localparam int RL  = 8;
    localparam int LAT = RL + 3;

    typedef struct {
        logic [0:RL-1] rdata;
        logic          par;
        logic [0:RL-1] ring;
        int            rsp_cyc;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic [0:`NCLK_WIDTH-1] nclk;
    logic                   req_val, req_rdy, req_wr;
    logic [0:RL-1]          req_wdata;
    logic                   rsp_val, rsp_rdy, rsp_par;
    logic [0:RL-1]          rsp_rdata;
    logic                   ring_hold, ring_sg, ring_scin, ring_scout;

    logic [0:RL-1] ring_m = 8'hA5;
    logic [0:RL-1] shadow = 8'hA5;
    exp_t          q[$];
    exp_t          e_new;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            acc_cnt = 0;
    int            last_acc = 0;
    bit            acc_seen = 0;
    bit            b2b = 0;
    bit            prev_val = 0;
    int            sg_cnt = 0;
    int            hold_cnt = 0;

    assign nclk = {clk, rst};
    assign ring_scout = ring_m[RL-1];

    tri_scan_ring_ctl #(.RING_LEN(RL), .CNT_W(6)) dut (
        .nclk       (nclk),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_wr     (req_wr),
        .req_wdata  (req_wdata),
        .rsp_val    (rsp_val),
        .rsp_rdy    (rsp_rdy),
        .rsp_rdata  (rsp_rdata),
        .rsp_par    (rsp_par),
        .ring_hold  (ring_hold),
        .ring_sg    (ring_sg),
        .ring_scin  (ring_scin),
        .ring_scout (ring_scout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Environment ring: latch 0 takes scin, last latch drives scout.
    always @(posedge clk) begin
        if (ring_sg && ring_hold) ring_m <= {ring_scin, ring_m[0:RL-2]};
    end

    function automatic logic par_of(input logic [0:RL-1] d);
`ifdef TRI_SCAN_RING_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: predicts acceptances and checks every response.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            sg_cnt   = 0;
            hold_cnt = 0;
            prev_val = 0;
        end else begin
            if (req_val && req_rdy) begin
                e_new.rdata = shadow;
                if (req_wr) shadow = req_wdata;
                e_new.ring    = shadow;
                e_new.par     = par_of(e_new.rdata);
                e_new.rsp_cyc = cyc + LAT;
                q.push_back(e_new);
                if (b2b && acc_seen) chk("b2b_spacing", 64'(cyc - last_acc), 64'(RL + 4));
                last_acc = cyc;
                acc_seen = 1;
                acc_cnt++;
            end
            if (!ring_sg) chk("scin_idle", 64'(ring_scin), 64'd0);
            if (ring_sg) sg_cnt++;
            if (ring_hold) hold_cnt++;
            if (rsp_val) begin
                if (q.size() == 0) begin
                    chk("rsp_without_req", 64'(q.size()), 64'd1);
                end else begin
                    if (!prev_val) begin
                        chk("rsp_latency", 64'(cyc), 64'(q[0].rsp_cyc));
                        chk("ring_after", 64'(ring_m), 64'(q[0].ring));
                        chk("sg_cycles", 64'(sg_cnt), 64'(RL));
                        chk("hold_cycles", 64'(hold_cnt), 64'(RL + 2));
                        sg_cnt   = 0;
                        hold_cnt = 0;
                    end
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(q[0].rdata));
                    chk("rsp_par", 64'(rsp_par), 64'(q[0].par));
                    if (rsp_rdy) void'(q.pop_front());
                end
            end
            prev_val = rsp_val && !rsp_rdy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [0:RL-1] wd);
        int n = 0;
        int a0 = acc_cnt;
        req_val   = 1'b1;
        req_wr    = wr;
        req_wdata = wd;
        do begin
            step();
            n++;
        end while (acc_cnt == a0 && n < 100);
        if (acc_cnt == a0) chk("accept_timeout", 64'(acc_cnt), 64'(a0 + 1));
        req_val = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_val && n < 100) begin
            step();
            n++;
        end
        if (!rsp_val) chk("rsp_timeout", 64'(rsp_val), 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q.size() != 0 || !req_rdy) && n < 200) begin
            step();
            n++;
        end
        if (q.size() != 0) chk("done_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_val   = 1'b0;
        req_wr    = 1'b0;
        req_wdata = '0;
        rsp_rdy   = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_rdy", 64'(req_rdy), 64'd1);
        chk("rst_rsp_val", 64'(rsp_val), 64'd0);
        chk("rst_ring_sg", 64'(ring_sg), 64'd0);
        chk("rst_ring_hold", 64'(ring_hold), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_par", 64'(rsp_par), 64'd0);
        step();

        // Write 0x3C over the 0xA5 ring, then read it back without disturbing it.
        issue(1'b1, 8'h3C);
        wait_done();
        chk("ring_is_3c", 64'(ring_m), 64'h3C);
        issue(1'b0, 8'(($urandom)));
        wait_done();
        chk("ring_kept_3c", 64'(ring_m), 64'h3C);

        // Back-pressure: response must hold and requests must be refused.
        rsp_rdy = 1'b0;
        issue(1'b1, 8'($urandom));
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            req_val   = 1'b1;
            req_wr    = 1'b1;
            req_wdata = 8'($urandom);
            @(negedge clk);
            chk("bp_req_rdy", 64'(req_rdy), 64'd0);
            chk("bp_rsp_val", 64'(rsp_val), 64'd1);
            step();
        end
        req_val = 1'b0;
        rsp_rdy = 1'b1;
        wait_done();

        // Reset in shift cycle 3 abandons the access.
        issue(1'b1, 8'($urandom));
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_rdy", 64'(req_rdy), 64'd1);
        chk("mid_rst_sg", 64'(ring_sg), 64'd0);
        chk("mid_rst_hold", 64'(ring_hold), 64'd0);
        chk("mid_rst_rsp_val", 64'(rsp_val), 64'd0);
        repeat (15) step();
        shadow = ring_m;
        issue(1'b1, 8'($urandom));
        wait_done();

        // Back-to-back requests with req_val held high.
        acc_seen = 0;
        b2b      = 1;
        req_val   = 1'b1;
        req_wr    = 1'($urandom);
        req_wdata = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            int a0 = acc_cnt;
            int n  = 0;
            while (acc_cnt == a0 && n < 100) begin
                step();
                n++;
            end
            if (acc_cnt == a0) chk("b2b_timeout", 64'(acc_cnt), 64'(a0 + 1));
            req_wr    = 1'($urandom);
            req_wdata = 8'($urandom);
        end
        req_val = 1'b0;
        b2b     = 0;
        wait_done();

        // Single set bit: parity follows the model (0 with the feature off).
        issue(1'b1, 8'h01);
        wait_done();
        issue(1'b0, 8'h00);
        wait_done();

        for (int i = 0; i < 20; i++) begin
            rsp_rdy = 1'($urandom);
            issue(1'($urandom), 8'($urandom));
            if (!rsp_rdy) begin
                wait_rsp();
                repeat ($urandom_range(1, 3)) step();
                rsp_rdy = 1'b1;
            end
            wait_done();
        end

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
